// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types, constants and helpers for the UART byte receiver.
//
// Contents:
//   uart_rx_state_t : receiver frame state (IDLE, START, DATA, STOP, BREAK)
//   UART_DATA_BITS  : payload bits per character (8N1 framing)
//   maj3()          : 2-of-3 majority vote used when UART_RX_MAJORITY_VOTE_EN
//                     is defined
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame progress of the receiver; BREAK parks the block while the line is
    // held low after a bad stop bit so a long break yields only one error.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // 2-of-3 majority of three line samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Metastability synchroniser: a STAGES-deep chain of flops that brings an
// asynchronous, idle-high line into the clk domain. Every flop resets to 1 so
// that reset never looks like a falling (start) edge on the UART line.
//
// Parameters:
//   STAGES : number of flops in the chain (2..4)
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous, active-high reset
//   i_d    : asynchronous input
//   o_q    : synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw input through the flop chain; reset fills it with idle level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= {STAGES{1'b1}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Byte-level 8N1 UART receiver feeding the RAM bridge command decoder.
// The asynchronous rx line is synchronised, each character is framed from its
// start edge, bits are sampled mid-bit, and a one-cycle strobe reports either
// a good byte (valid_out) or a low stop bit (framing_error_out).
//
// Parameters:
//   CLOCKS_PER_BAUD : clk_in cycles per UART bit (4..65535, 6..65535 with vote)
//   SYNC_STAGES     : synchroniser depth on rx_in (2..4)
// Ports:
//   clk_in            : system clock
//   rst_in            : synchronous, active-high reset
//   rx_in             : asynchronous UART line, idle high
//   data_out          : last good byte, held between strobes
//   valid_out         : one-cycle strobe, data_out valid in the same cycle
//   framing_error_out : one-cycle strobe when the stop bit samples low
//   busy_out          : high while a frame is in progress (state != IDLE)
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN : when defined, every bit decision is the 2-of-3
//   majority of the synchronised line at sample point -1, 0 and +1, taken one
//   cycle after the sample point. This rejects a single-cycle glitch at
//   mid-bit. When undefined, one sample is taken at the sample point.
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 33,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       framing_error_out,
    output logic       busy_out
);

    localparam int CNT_W = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam int HALF  = CLOCKS_PER_BAUD / 2;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);

    // The start-bit decision moves one cycle later with voting. Because the
    // later states count whole bit periods from that decision, every data and
    // stop decision inherits the same one-cycle shift automatically.
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(HALF);
`else
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(HALF - 1);
`endif

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    logic                      w_sample;
    uart_rx_state_t            r_state;
    logic [CNT_W-1:0]          r_baud_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      r_busy;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .i_clk (clk_in),
        .i_rst (rst_in),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // r_hist[0] is rx_s one cycle ago (the sample point when a decision is
    // taken), r_hist[1] is two cycles ago (sample point minus one).
    logic [1:0] r_hist;

    // Keep the two previous synchronised line values for the vote.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    // Frame state machine: start qualification, data shift, stop check, break wait.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_baud_cnt <= CNT_ZERO;
            r_bit_idx  <= 3'd0;
            r_shreg    <= {UART_DATA_BITS{1'b0}};
            r_data     <= {UART_DATA_BITS{1'b0}};
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless re-armed below.
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= START;
                        r_baud_cnt <= CNT_ZERO;
                        r_busy     <= 1'b1;
                    end else begin
                        r_baud_cnt <= CNT_ZERO;
                    end
                end

                START: begin
                    if (r_baud_cnt == CNT_START) begin
                        r_baud_cnt <= CNT_ZERO;
                        if (!w_sample) begin
                            r_state   <= DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // Line was high again at mid-start: a glitch, drop it.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (r_baud_cnt == CNT_LAST) begin
                        r_baud_cnt <= CNT_ZERO;
                        // LSB arrives first, so shift right and insert at the top.
                        r_shreg <= {w_sample, r_shreg[UART_DATA_BITS-1:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (r_baud_cnt == CNT_LAST) begin
                        r_baud_cnt <= CNT_ZERO;
                        if (w_sample) begin
                            // Leaving at mid-stop lets the next start edge be
                            // caught even with no idle time between frames.
                            r_data  <= r_shreg;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end

                BREAK: begin
                    // Stay here for as long as the line is low; one error only.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= BREAK;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_baud_cnt <= CNT_ZERO;
                    r_bit_idx  <= 3'd0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign data_out          = r_data;
    assign valid_out         = r_valid;
    assign framing_error_out = r_ferr;
    assign busy_out          = r_busy;

endmodule
